// File: rtl/cdb_arbiter_pkg.sv
// rtl/cdb_arbiter_pkg.sv - CDB payload type and functional-unit indices
package cdb_arbiter_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
    logic [5:0]  preg;
    logic [4:0]  rob_id;
  } cdb_t;

  localparam int FU_ALU = 0;
  localparam int FU_MUL = 1;
  localparam int FU_DIV = 2;
  localparam int FU_LSU = 3;

endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// rtl/cdb_arbiter_rr_picker.sv - round-robin pick of one request starting at ptr
module cdb_arbiter_rr_picker #(
  parameter int N = 4,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx,
  output logic          any
);

  logic [PW:0]   pos;
  logic [PW-1:0] sel;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = '0;
    sel   = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, ptr} + (PW+1)'(k);
      if (pos >= (PW+1)'(N)) pos = pos - (PW+1)'(N);
      sel = pos[PW-1:0];
      if (!any && req[sel]) begin
        any        = 1'b1;
        idx        = sel;
        grant[sel] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin common data bus arbiter with registered broadcast
// CDB_ARB_PERF_EN adds saturating grant and conflict counters.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  cdb_t                       req_cdb [NUM_REQ],
  output logic [NUM_REQ-1:0]         cdb_grant,
  output cdb_t                       cdb_out,
  output logic [$clog2(NUM_REQ)-1:0] rr_ptr
`ifdef CDB_ARB_PERF_EN
  ,
  output logic [CNT_W-1:0]           perf_grant_cnt [NUM_REQ],
  output logic [CNT_W-1:0]           perf_conflict_cnt
`endif
);

  localparam int PW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || CNT_W < 1) begin : g_param_check
    $error("cdb_arbiter: NUM_REQ must be 2..8 and CNT_W positive");
  end

  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_live;
  logic [PW-1:0]      win_idx;
  logic               win_any;
  cdb_t               out_q;

  always_comb begin
    req_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) req_valid[i] = req_cdb[i].valid;
  end

  assign req_live = flush ? '0 : req_valid;

  cdb_arbiter_rr_picker #(.N(NUM_REQ)) u_picker (
    .req   (req_live),
    .ptr   (rr_ptr),
    .grant (cdb_grant),
    .idx   (win_idx),
    .any   (win_any)
  );

  // A flush also hides a broadcast already sitting in the output register.
  always_comb begin
    cdb_out       = out_q;
    cdb_out.valid = out_q.valid & ~flush;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q  <= '0;
      rr_ptr <= '0;
    end else begin
      out_q.valid <= win_any;
      if (win_any) begin
        out_q.data   <= req_cdb[win_idx].data;
        out_q.preg   <= req_cdb[win_idx].preg;
        out_q.rob_id <= req_cdb[win_idx].rob_id;
        rr_ptr       <= (win_idx == PW'(NUM_REQ-1)) ? '0 : win_idx + PW'(1);
      end
    end
  end

`ifdef CDB_ARB_PERF_EN
  logic conflict;
  assign conflict = !flush && ($countones(req_valid) > 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) perf_grant_cnt[i] <= '0;
      perf_conflict_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (cdb_grant[i] && perf_grant_cnt[i] != '1)
          perf_grant_cnt[i] <= perf_grant_cnt[i] + CNT_W'(1);
      end
      if (conflict && perf_conflict_cnt != '1)
        perf_conflict_cnt <= perf_conflict_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed and randomized checks of cdb_arbiter against a behavioural model
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int CW = 32;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   flush = 1'b0;
  cdb_t                   req_cdb [N];
  logic [N-1:0]           cdb_grant;
  cdb_t                   cdb_out;
  logic [$clog2(N)-1:0]   rr_ptr;
`ifdef CDB_ARB_PERF_EN
  logic [CW-1:0]          perf_grant_cnt [N];
  logic [CW-1:0]          perf_conflict_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cdb_arbiter #(.NUM_REQ(N), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .req_cdb   (req_cdb),
    .cdb_grant (cdb_grant),
    .cdb_out   (cdb_out),
    .rr_ptr    (rr_ptr)
`ifdef CDB_ARB_PERF_EN
    ,
    .perf_grant_cnt    (perf_grant_cnt),
    .perf_conflict_cnt (perf_conflict_cnt)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Behavioural model: pointer as an integer, broadcast as a copy of the winner.
  int     m_ptr;
  logic   m_valid;
  cdb_t   m_out;
  longint m_gcnt [N];
  longint m_ccnt;
  localparam longint SAT = (64'd1 << CW) - 1;

  function automatic int pick(input int ptr);
    if (flush) return -1;
    for (int k = 0; k < N; k++)
      if (req_cdb[(ptr + k) % N].valid) return (ptr + k) % N;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int g;
    int nv;
    if (!rst_n) begin
      m_ptr = 0; m_valid = 1'b0; m_out = '0; m_ccnt = 0;
      for (int i = 0; i < N; i++) m_gcnt[i] = 0;
    end else begin
      g  = pick(m_ptr);
      nv = 0;
      for (int i = 0; i < N; i++) nv += int'(req_cdb[i].valid);
      if (nv > 1 && !flush && m_ccnt < SAT) m_ccnt++;
      if (g >= 0) begin
        m_out   = req_cdb[g];
        m_valid = 1'b1;
        m_ptr   = (g + 1) % N;
        if (m_gcnt[g] < SAT) m_gcnt[g]++;
      end else begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin : compare
    int g;
    logic [N-1:0] eg;
    if (rst_n) begin
      g  = pick(m_ptr);
      eg = (g >= 0) ? N'(1) << g : '0;
      chk("m_grant", cdb_grant, eg);
      chk("m_ptr", rr_ptr, m_ptr);
      chk("m_valid", cdb_out.valid, m_valid && !flush);
      chk("m_payload", {cdb_out.data, cdb_out.preg, cdb_out.rob_id},
          {m_out.data, m_out.preg, m_out.rob_id});
`ifdef CDB_ARB_PERF_EN
      for (int i = 0; i < N; i++) chk("m_gcnt", perf_grant_cnt[i], m_gcnt[i]);
      chk("m_ccnt", perf_conflict_cnt, m_ccnt);
`endif
    end
  end

  task automatic set_req(input int i, input logic v, input logic [31:0] d,
                         input logic [5:0] p, input logic [4:0] r);
    req_cdb[i].valid = v; req_cdb[i].data = d; req_cdb[i].preg = p; req_cdb[i].rob_id = r;
  endtask

  task automatic new_payload(input int i, input logic v);
    set_req(i, v, $urandom, 6'($urandom), 5'($urandom));
  endtask

  task automatic clear_all();
    for (int i = 0; i < N; i++) req_cdb[i] = '0;
  endtask

  logic [N-1:0] g_seen;

  initial begin
    clear_all();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_ptr", rr_ptr, 0);
    chk("reset_valid", cdb_out.valid, 0);
    chk("idle_grant", cdb_grant, 0);

    // Single MUL request
    @(posedge clk); #1 set_req(FU_MUL, 1'b1, 32'h0000_1234, 6'd9, 5'd3);
    @(negedge clk); chk("mul_grant", cdb_grant, 4'b0010);
    @(posedge clk); #1 req_cdb[FU_MUL].valid = 1'b0;
    @(negedge clk);
    chk("mul_out", {cdb_out.valid, cdb_out.data, cdb_out.preg, cdb_out.rob_id},
        {1'b1, 32'h0000_1234, 6'd9, 5'd3});
    chk("mul_ptr", rr_ptr, 2);

    // Pointer at 2: LSU beats ALU, then ALU
    @(posedge clk); #1
    set_req(FU_ALU, 1'b1, 32'hA0A0, 6'd1, 5'd1);
    set_req(FU_LSU, 1'b1, 32'hB0B0, 6'd2, 5'd2);
    @(negedge clk); chk("prio_lsu", cdb_grant, 4'b1000);
    @(posedge clk); #1 req_cdb[FU_LSU].valid = 1'b0;
    @(negedge clk);
    chk("prio_alu", cdb_grant, 4'b0001);
    chk("prio_lsu_out", cdb_out.data, 32'hB0B0);
    @(posedge clk); #1 req_cdb[FU_ALU].valid = 1'b0;
    @(negedge clk);
    chk("prio_ptr", rr_ptr, 1);
    chk("prio_alu_out", cdb_out.data, 32'hA0A0);

    // Flush with requests pending, then flush right after a grant
    @(posedge clk); #1
    set_req(FU_ALU, 1'b1, 32'hC0, 6'd4, 5'd4);
    set_req(FU_DIV, 1'b1, 32'hD0, 6'd5, 5'd5);
    flush = 1'b1;
    @(negedge clk); chk("flush_grant", cdb_grant, 0);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_valid", cdb_out.valid, 0);
    chk("flush_ptr", rr_ptr, 1);
    chk("post_flush_grant", cdb_grant, 4'b0100);
    @(posedge clk); #1 flush = 1'b1; req_cdb[FU_DIV].valid = 1'b0;
    @(negedge clk);
    chk("flush_hide", cdb_out.valid, 0);
    @(posedge clk); #1 flush = 1'b0; req_cdb[FU_ALU].valid = 1'b0;
    @(negedge clk);
    chk("flush_drop", cdb_out.valid, 0);
    chk("flush_ptr2", rr_ptr, 3);

    // Async reset while a broadcast is visible
    @(posedge clk); #1 set_req(FU_MUL, 1'b1, 32'h55, 6'd6, 5'd6);
    @(posedge clk); #1 req_cdb[FU_MUL].valid = 1'b0;
    chk("pre_rst_valid", cdb_out.valid, 1);
    chk("pre_rst_ptr", rr_ptr, 2);
    #1 rst_n = 1'b0;
    #1;
    chk("async_valid", cdb_out.valid, 0);
    chk("async_ptr", rr_ptr, 0);
    #1 rst_n = 1'b1;

    // All four continuously valid: 0,1,2,3,0 each broadcast once in order
    @(posedge clk); #1
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 32'h100 + i, 6'(i), 5'(i));
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k < 5) chk("rr_grant", cdb_grant, 4'b0001 << (k % 4));
      chk("rr_ptr", rr_ptr, k % 4);
      if (k > 0) chk("rr_out", cdb_out.data, 32'h100 + ((k - 1) % 4) + ((k - 1) / 4) * 16);
      g_seen = cdb_grant;
      @(posedge clk); #1
      for (int i = 0; i < N; i++)
        if (g_seen[i]) req_cdb[i].data = req_cdb[i].data + 32'h10;
      if (k == 4) clear_all();
    end

    // Randomized traffic obeying the requester contract
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk); g_seen = cdb_grant;
      @(posedge clk); #1
      flush = ($urandom_range(0, 9) == 0);
      for (int i = 0; i < N; i++) begin
        if (g_seen[i]) new_payload(i, 1'($urandom_range(0, 1)));
        else if (!req_cdb[i].valid) new_payload(i, $urandom_range(0, 2) == 0);
      end
    end
    flush = 1'b0;
    clear_all();

`ifdef CDB_ARB_PERF_EN
    @(posedge clk); #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1
    set_req(FU_ALU, 1'b1, 32'h1, 6'd1, 5'd1);
    set_req(FU_MUL, 1'b1, 32'h2, 6'd2, 5'd2);
    repeat (10) @(posedge clk);
    #1 clear_all();
    @(negedge clk);
    chk("perf_alu", perf_grant_cnt[0], 5);
    chk("perf_mul", perf_grant_cnt[1], 5);
    chk("perf_conf", perf_conflict_cnt, 10);
`endif

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
